fetch_queue: RTL and testbench

Instruction fetch stage that sits directly downstream of the program counter register. It accepts fetch addresses from the PC stage and issues them to instruction memory over a valid/ready request channel. In-order memory responses are paired with their PCs and buffered in a DEPTH-entry queue that feeds decode. It also handles pipeline flushes, discarding stale in-flight responses after a branch or jump redirect.

---
 rtl/fetch_queue.sv | 123 ++++++++++++
 tb/tb_fetch_queue.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues PCs to instruction memory under a credit limit,
// pairs in-order responses with their PCs, and squashes stale responses after a flush.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    input  logic            pc_valid,
    output logic            pc_ready,
    input  logic            flush,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    output logic            proto_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int UW = AW + 3;

    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_out_cnt;
    logic [CW-1:0]   r_drop_cnt;
    logic [AW-1:0]   r_pend_wr;
    logic [AW-1:0]   r_pend_rd;
    logic [AW-1:0]   r_q_wr;
    logic [AW-1:0]   r_q_rd;
    logic            r_proto_err;
    logic [XLEN-1:0] r_pend_pc [DEPTH];
    logic [XLEN-1:0] r_q_pc    [DEPTH];
    logic [XLEN-1:0] r_q_data  [DEPTH];

    logic [UW-1:0]   w_used;
    logic            w_credit;
    logic            w_fire;
    logic            w_resp_drop;
    logic            w_resp_live;
    logic            w_resp_unexp;
    logic            w_resp_known;
    logic            w_pop;

    // Every queued, live or doomed response holds one credit, so the queue cannot overflow.
    assign w_used   = UW'(r_cnt) + UW'(r_out_cnt) + UW'(r_drop_cnt);
    assign w_credit = (w_used < UW'(DEPTH));

    assign imem_req_valid = pc_valid & w_credit & ~flush & reset;
    assign pc_ready       = imem_req_valid & imem_req_ready;
    assign imem_req_addr  = reset ? pc_in : '0;
    assign w_fire         = pc_ready;

    assign w_resp_drop  = imem_resp_valid & (r_drop_cnt != '0);
    assign w_resp_live  = imem_resp_valid & (r_drop_cnt == '0) & (r_out_cnt != '0);
    assign w_resp_unexp = imem_resp_valid & (r_drop_cnt == '0) & (r_out_cnt == '0);
    assign w_resp_known = imem_resp_valid & ~w_resp_unexp;

    assign inst_valid = (r_cnt != '0);
    assign inst_data  = inst_valid ? r_q_data[r_q_rd] : '0;
    assign inst_pc    = inst_valid ? r_q_pc[r_q_rd] : '0;
    assign w_pop      = inst_valid & inst_ready;
    assign proto_err  = r_proto_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_out_cnt   <= '0;
            r_drop_cnt  <= '0;
            r_pend_wr   <= '0;
            r_pend_rd   <= '0;
            r_q_wr      <= '0;
            r_q_rd      <= '0;
            r_proto_err <= 1'b0;
        end else if (flush) begin
            // Live requests become doomed; a response landing now retires one of them.
            r_cnt      <= '0;
            r_out_cnt  <= '0;
            r_pend_wr  <= '0;
            r_pend_rd  <= '0;
            r_q_wr     <= '0;
            r_q_rd     <= '0;
            r_drop_cnt <= r_drop_cnt + r_out_cnt - CW'(w_resp_known);
            if (w_resp_unexp) begin
                r_proto_err <= 1'b1;
            end
        end else begin
            if (w_fire) begin
                r_pend_wr <= r_pend_wr + 1'b1;
            end
            if (w_resp_live) begin
                r_pend_rd <= r_pend_rd + 1'b1;
                r_q_wr    <= r_q_wr + 1'b1;
            end
            if (w_pop) begin
                r_q_rd <= r_q_rd + 1'b1;
            end
            r_out_cnt <= r_out_cnt + CW'(w_fire) - CW'(w_resp_live);
            r_cnt     <= r_cnt + CW'(w_resp_live) - CW'(w_pop);
            if (w_resp_drop) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end
            if (w_resp_unexp) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_pend_pc[r_pend_wr] <= pc_in;
        end
        if (w_resp_live & ~flush) begin
            r_q_pc[r_q_wr]   <= r_pend_pc[r_pend_rd];
            r_q_data[r_q_wr] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written corner sequences and
// randomized traffic checked cycle by cycle against a queue-based reference model.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] pc_in;
    logic            pc_valid;
    logic            pc_ready;
    logic            flush;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            inst_valid;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;
    logic            proto_err;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .flush(flush), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .inst_valid(inst_valid), .inst_data(inst_data),
        .inst_pc(inst_pc), .inst_ready(inst_ready), .proto_err(proto_err)
    );

    // Reference model: plain queues of instructions and pending PCs plus a stale-response count.
    typedef struct { logic [31:0] pc; logic [31:0] data; } inst_t;
    inst_t       mq[$];
    logic [31:0] mpend[$];
    int          mdrop;
    bit          mperr;

    // Memory model: in-order responses, each no earlier than its due cycle.
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t memq[$];

    typedef struct {
        logic pv; logic [31:0] pc; logic rv; logic [31:0] rd; logic ir; logic fl;
        logic e_pr; logic e_iv; logic [31:0] e_ipc; logic [31:0] e_idat; logic e_perr;
    } vec_t;
    vec_t vt[22];

    int          n_tests, n_fail, cyc, n_acc;
    bit          use_mem, rand_rdy, pc_auto;
    int          lat_min, lat_max, resp_pct, rdy_pct;
    logic [31:0] next_pc;
    logic [31:0] got[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   mem_word = 32'h00000013;
            32'h4:   mem_word = 32'h00500093;
            32'h8:   mem_word = 32'h00A00113;
            default: mem_word = a ^ 32'hC0DE0000;
        endcase
    endfunction

    function automatic vec_t mk(input logic pv, input logic [31:0] pc, input logic rv,
                                input logic [31:0] rd, input logic ir, input logic fl,
                                input logic e_pr, input logic e_iv, input logic [31:0] e_ipc,
                                input logic [31:0] e_idat, input logic e_perr);
        vec_t v;
        v.pv = pv; v.pc = pc; v.rv = rv; v.rd = rd; v.ir = ir; v.fl = fl;
        v.e_pr = e_pr; v.e_iv = e_iv; v.e_ipc = e_ipc; v.e_idat = e_idat; v.e_perr = e_perr;
        return v;
    endfunction

    // One clock cycle: entered and left just after a falling edge.
    task automatic step();
        bit    m_rv, m_fire, m_pop, d_fire, d_resp;
        int    used, due;
        inst_t e;
        if (use_mem) begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
            if (memq.size() > 0 && memq[0].due <= cyc && $urandom_range(99) < resp_pct) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(memq[0].addr);
            end
            if (rand_rdy) imem_req_ready = ($urandom_range(99) < rdy_pct);
        end
        if (pc_auto) pc_in = next_pc;
        #1;
        used = mq.size() + mpend.size() + mdrop;
        m_rv = pc_valid && (used < DEPTH) && !flush;
        chk("model imem_req_valid", imem_req_valid, m_rv);
        chk("model pc_ready", pc_ready, m_rv && imem_req_ready);
        if (m_rv) chk("model imem_req_addr", imem_req_addr, pc_in);
        chk("model inst_valid", inst_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("model inst_pc", inst_pc, mq[0].pc);
            chk("model inst_data", inst_data, mq[0].data);
        end
        chk("model proto_err", proto_err, mperr);
        m_fire = m_rv && imem_req_ready;
        m_pop  = (mq.size() > 0) && inst_ready;
        d_fire = imem_req_valid && imem_req_ready;
        d_resp = imem_resp_valid;
        if (inst_valid && inst_ready && !flush) got.push_back(inst_pc);
        if (flush) begin
            if (imem_resp_valid) begin
                if (mdrop + mpend.size() == 0) mperr = 1'b1;
                else mdrop = mdrop + mpend.size() - 1;
            end else begin
                mdrop = mdrop + mpend.size();
            end
            mq.delete();
            mpend.delete();
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (imem_resp_valid) begin
                if (mdrop > 0) mdrop--;
                else if (mpend.size() > 0) begin
                    e.pc   = mpend.pop_front();
                    e.data = imem_resp_data;
                    mq.push_back(e);
                end else mperr = 1'b1;
            end
            if (m_fire) mpend.push_back(pc_in);
        end
        if (use_mem) begin
            if (d_resp && memq.size() > 0) void'(memq.pop_front());
            if (d_fire) begin
                due = cyc + $urandom_range(lat_max, lat_min);
                if (memq.size() > 0 && memq[memq.size()-1].due > due) due = memq[memq.size()-1].due;
                memq.push_back('{addr: pc_in, due: due});
            end
        end
        if (d_fire) n_acc++;
        if (pc_auto && d_fire) next_pc = next_pc + 32'h4;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; n_acc = 0; mdrop = 0; mperr = 1'b0;
        use_mem = 1'b0; rand_rdy = 1'b0; pc_auto = 1'b0;
        lat_min = 1; lat_max = 1; resp_pct = 100; rdy_pct = 100; next_pc = '0;
        reset = 1'b0; pc_valid = 1'b1; pc_in = 32'h40; flush = 1'b0; imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0; imem_resp_data = '0; inst_ready = 1'b0;

        vt[0]  = mk(1, 32'h0,  0, 32'h0,        1, 0, 1, 0, 32'h0,  32'h0,        0);
        vt[1]  = mk(1, 32'h4,  1, 32'h00000013, 1, 0, 1, 0, 32'h0,  32'h0,        0);
        vt[2]  = mk(1, 32'h8,  1, 32'h00500093, 1, 0, 1, 1, 32'h0,  32'h00000013, 0);
        vt[3]  = mk(0, 32'h0,  1, 32'h00A00113, 1, 0, 0, 1, 32'h4,  32'h00500093, 0);
        vt[4]  = mk(0, 32'h0,  0, 32'h0,        1, 0, 0, 1, 32'h8,  32'h00A00113, 0);
        vt[5]  = mk(0, 32'h0,  0, 32'h0,        1, 0, 0, 0, 32'h0,  32'h0,        0);
        vt[6]  = mk(1, 32'h20, 0, 32'h0,        0, 0, 1, 0, 32'h0,  32'h0,        0);
        vt[7]  = mk(1, 32'h24, 1, 32'hAAAA0020, 0, 0, 1, 0, 32'h0,  32'h0,        0);
        vt[8]  = mk(1, 32'h28, 0, 32'h0,        0, 0, 1, 1, 32'h20, 32'hAAAA0020, 0);
        vt[9]  = mk(0, 32'h0,  1, 32'hBBBB0024, 1, 1, 0, 1, 32'h20, 32'hAAAA0020, 0);
        vt[10] = mk(0, 32'h0,  0, 32'h0,        1, 0, 0, 0, 32'h0,  32'h0,        0);
        vt[11] = mk(0, 32'h0,  1, 32'hCCCC0028, 1, 0, 0, 0, 32'h0,  32'h0,        0);
        vt[12] = mk(1, 32'h30, 0, 32'h0,        1, 0, 1, 0, 32'h0,  32'h0,        0);
        vt[13] = mk(0, 32'h0,  1, 32'hDDDD0030, 1, 0, 0, 0, 32'h0,  32'h0,        0);
        vt[14] = mk(0, 32'h0,  0, 32'h0,        1, 0, 0, 1, 32'h30, 32'hDDDD0030, 0);
        vt[15] = mk(0, 32'h0,  0, 32'h0,        1, 0, 0, 0, 32'h0,  32'h0,        0);
        vt[16] = mk(0, 32'h0,  1, 32'h12345678, 1, 0, 0, 0, 32'h0,  32'h0,        0);
        vt[17] = mk(0, 32'h0,  0, 32'h0,        1, 0, 0, 0, 32'h0,  32'h0,        1);
        vt[18] = mk(1, 32'h40, 0, 32'h0,        1, 0, 1, 0, 32'h0,  32'h0,        1);
        vt[19] = mk(0, 32'h0,  1, 32'hEEEE0040, 1, 0, 0, 0, 32'h0,  32'h0,        1);
        vt[20] = mk(0, 32'h0,  0, 32'h0,        1, 0, 0, 1, 32'h40, 32'hEEEE0040, 1);
        vt[21] = mk(0, 32'h0,  0, 32'h0,        1, 0, 0, 0, 32'h0,  32'h0,        1);

        #2;
        chk("reset pc_ready", pc_ready, 0);
        chk("reset imem_req_valid", imem_req_valid, 0);
        chk("reset inst_valid", inst_valid, 0);
        chk("reset proto_err", proto_err, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        pc_valid = 1'b0;

        for (int i = 0; i < 22; i++) begin
            pc_valid = vt[i].pv; pc_in = vt[i].pc; imem_resp_valid = vt[i].rv;
            imem_resp_data = vt[i].rd; inst_ready = vt[i].ir; flush = vt[i].fl;
            #1;
            chk($sformatf("vec%0d pc_ready", i), pc_ready, vt[i].e_pr);
            chk($sformatf("vec%0d inst_valid", i), inst_valid, vt[i].e_iv);
            if (vt[i].e_iv) begin
                chk($sformatf("vec%0d inst_pc", i), inst_pc, vt[i].e_ipc);
                chk($sformatf("vec%0d inst_data", i), inst_data, vt[i].e_idat);
            end
            chk($sformatf("vec%0d proto_err", i), proto_err, vt[i].e_perr);
            step();
        end
        flush = 1'b0;

        // Fill three entries, then assert reset between clock edges.
        inst_ready = 1'b0;
        pc_valid = 1'b1; pc_in = 32'h50; imem_resp_valid = 1'b0; step();
        pc_in = 32'h54; imem_resp_valid = 1'b1; imem_resp_data = 32'h11110050; step();
        pc_in = 32'h58; imem_resp_data = 32'h11110054; step();
        pc_valid = 1'b0; imem_resp_data = 32'h11110058; step();
        imem_resp_valid = 1'b0; pc_valid = 1'b1; pc_in = 32'h5C;
        #1;
        chk("pre-reset inst_valid", inst_valid, 1);
        chk("pre-reset pc_ready", pc_ready, 1);
        reset = 1'b0;
        #1;
        chk("async reset inst_valid", inst_valid, 0);
        chk("async reset pc_ready", pc_ready, 0);
        chk("async reset imem_req_valid", imem_req_valid, 0);
        chk("async reset proto_err", proto_err, 0);
        mq.delete(); mpend.delete(); mdrop = 0; mperr = 1'b0; memq.delete();
        pc_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Backpressure: only DEPTH requests may be outstanding while decode stalls.
        use_mem = 1'b1; lat_min = 1; lat_max = 1; resp_pct = 100; rand_rdy = 1'b0;
        imem_req_ready = 1'b1; pc_auto = 1'b1; next_pc = 32'h0; pc_valid = 1'b1;
        inst_ready = 1'b0; n_acc = 0; got.delete();
        repeat (10) step();
        chk("backpressure accepted", n_acc, DEPTH);
        #1;
        chk("backpressure pc_ready", pc_ready, 0);
        inst_ready = 1'b1;
        for (int k = 0; k < 60 && got.size() < 8; k++) begin
            pc_valid = (next_pc < 32'h20);
            step();
        end
        chk("backpressure drained", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk($sformatf("backpressure pc%0d", i), got[i], 32'(i * 4));
        pc_valid = 1'b0;
        repeat (6) step();

        // Flush with two requests in flight, then redirect to 0x100.
        pc_auto = 1'b0; lat_min = 3; lat_max = 3; got.delete();
        pc_valid = 1'b1; pc_in = 32'h10; step();
        pc_in = 32'h14; step();
        pc_valid = 1'b0; flush = 1'b1; step();
        flush = 1'b0; pc_valid = 1'b1; pc_in = 32'h100; step();
        pc_valid = 1'b0;
        for (int k = 0; k < 20 && got.size() == 0; k++) step();
        if (got.size() == 0) chk("flush first inst timeout", 0, 1);
        else chk("flush first inst_pc", got[0], 32'h100);
        repeat (6) step();

        // Randomized traffic with memory stalls, variable latency and flushes.
        lat_min = 1; lat_max = 3; resp_pct = 70; rand_rdy = 1'b1; rdy_pct = 75;
        pc_auto = 1'b1; next_pc = 32'h1000;
        for (int k = 0; k < 3000; k++) begin
            pc_valid   = ($urandom_range(99) < 80);
            inst_ready = ($urandom_range(99) < 70);
            flush      = ($urandom_range(99) < 4);
            if (flush) next_pc = $urandom & 32'hFFFF_FFFC;
            step();
        end
        flush = 1'b0; pc_valid = 1'b0; inst_ready = 1'b1; resp_pct = 100;
        repeat (30) step();
        chk("random drain inst_valid", inst_valid, 0);
        chk("random proto_err", proto_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
